// File: rtl/dm_store_buf_pkg.sv
// dm_store_buf_pkg: store encodings, FSM states, entry layout and alignment helpers for dm_store_buffer
package dm_store_buf_pkg;
  localparam int OP_W   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam logic [OP_W-1:0] ST_SW = 2'd0;
  localparam logic [OP_W-1:0] ST_SH = 2'd1;
  localparam logic [OP_W-1:0] ST_SB = 2'd2;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } entry_t;
  function automatic logic is_word(input logic [OP_W-1:0] op);
    return op != ST_SH && op != ST_SB;
  endfunction
  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
    return is_word(op) ? a != 2'b00 : (op == ST_SH) ? a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: little-endian lane insert of sb/sh data into an old DM word (sw passes data through)
// ports: op, lane = addr[1:0], old_word = raw DM word, data = right-justified store data, merged = result
module dm_byte_merge
  import dm_store_buf_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] merged
);
  always_comb begin
    merged = old_word;
    if (op == ST_SB) merged[{lane, 3'b000} +: 8] = data[7:0];
    else if (op == ST_SH) merged[{lane[1], 4'b0000} +: 16] = data[15:0];
    else merged = data;
  end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store queue with read-modify-write for sh/sb and load hazard detection
// ports: st_* store request in (st_ready = !full, st_misalign pulse), ld_* load probe (ld_hazard),
//        dm_* word-wide DM port (dm_req/dm_grant handshake, dm_rd raw read word), count/empty occupancy.
// DM_STORE_BUF_FWD_EN adds ld_fwd_valid/ld_fwd_data forwarding from the youngest matching sw.
module dm_store_buffer
  import dm_store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_valid,
  input  logic [1:0]         st_op,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  input  logic [31:0]        st_pc,
  output logic               st_ready,
  output logic               st_misalign,
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  output logic               ld_hazard,
`ifdef DM_STORE_BUF_FWD_EN
  output logic               ld_fwd_valid,
  output logic [31:0]        ld_fwd_data,
`endif
  output logic               dm_req,
  input  logic               dm_grant,
  output logic [31:0]        dm_addr,
  output logic               dm_we,
  output logic [31:0]        dm_wd,
  output logic [31:0]        dm_pc,
  input  logic [31:0]        dm_rd,
  output logic [PTR_W:0]     count,
  output logic               empty
);
  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] merge_q, merge_d, merged;
  logic              misalign_q, misalign_d;
  logic              push, pop, hit, bad;
  logic              unused;
`ifdef DM_STORE_BUF_FWD_EN
  logic              y_word;
  logic [DATA_W-1:0] y_data;
`endif
  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign empty       = count_q == '0;
  assign st_ready    = count_q != (PTR_W+1)'(DEPTH);
  assign st_misalign = misalign_q;
  assign dm_req      = !empty || state_q == WRITE;
  assign dm_addr     = dm_req ? {head.addr[31:2], 2'b00} : '0;
  assign dm_pc       = dm_req ? head.pc : '0;
  assign unused      = ^ld_addr[1:0];
  dm_byte_merge u_merge (
    .op      (head.op),
    .lane    (head.addr[1:0]),
    .old_word(dm_rd),
    .data    (head.data),
    .merged  (merged)
  );
  always_comb begin
    bad        = misaligned(st_op, st_addr[1:0]);
    push       = st_valid && st_ready && !bad;
    misalign_d = st_valid && st_ready && bad;
    state_d    = state_q;
    merge_d    = merge_q;
    pop        = 1'b0;
    dm_we      = 1'b0;
    dm_wd      = '0;
    case (state_q)
      IDLE: if (!empty && dm_grant) begin
        if (is_word(head.op)) begin
          dm_we = 1'b1;
          dm_wd = head.data;
          pop   = 1'b1;
        end else begin
          merge_d = merged;
          state_d = WRITE;
        end
      end
      READ: if (dm_grant) begin
        merge_d = merged;
        state_d = WRITE;
      end
      WRITE: begin
        // losing the grant here lets another master touch DM, so the merge is stale and must be re-read
        merge_d = '0;
        state_d = dm_grant ? IDLE : READ;
        dm_we   = dm_grant;
        dm_wd   = dm_grant ? merge_q : '0;
        pop     = dm_grant;
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_comb begin
    hit = 1'b0;
`ifdef DM_STORE_BUF_FWD_EN
    y_word = 1'b0;
    y_data = '0;
`endif
    // walk oldest to youngest so the last match is the youngest
    for (int i = 0; i < DEPTH; i++)
      if ((PTR_W+1)'(i) < count_q && mem_q[rd_ptr_q + PTR_W'(i)].addr[31:2] == ld_addr[31:2]) begin
        hit = 1'b1;
`ifdef DM_STORE_BUF_FWD_EN
        y_word = is_word(mem_q[rd_ptr_q + PTR_W'(i)].op);
        y_data = mem_q[rd_ptr_q + PTR_W'(i)].data;
`endif
      end
  end
`ifdef DM_STORE_BUF_FWD_EN
  assign ld_fwd_valid = ld_valid && hit && y_word;
  assign ld_fwd_data  = ld_fwd_valid ? y_data : '0;
  assign ld_hazard    = ld_valid && hit && !y_word;
`else
  assign ld_hazard    = ld_valid && hit;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      merge_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      merge_q    <= merge_d;
      misalign_q <= misalign_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {st_op, st_addr, st_data, st_pc};
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: scoreboard bench with a behavioural DM and store-queue model for dm_store_buffer
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } st_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        st_valid = 1'b0, ld_valid = 1'b0, dm_grant = 1'b0;
  logic [1:0]  st_op = '0;
  logic [31:0] st_addr = '0, st_data = '0, st_pc = '0, ld_addr = '0;
  logic        st_ready, st_misalign, ld_hazard, dm_req, dm_we, empty;
  logic [31:0] dm_addr, dm_wd, dm_pc, dm_rd;
  logic [2:0]  count;
`ifdef DM_STORE_BUF_FWD_EN
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
`endif
  logic [31:0] ram [64];
  st_t         sb[$];
  st_t         stage;
  bit          stage_v = 0;
  logic        exp_mis = 1'b0;
  int          n_vec = 0, n_err = 0, pc_ctr = 0;
  always #5 clk = ~clk;
  assign dm_rd = ram[dm_addr[7:2]];
  dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
`ifdef DM_STORE_BUF_FWD_EN
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
`endif
    .dm_req(dm_req), .dm_grant(dm_grant), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wd(dm_wd),
    .dm_pc(dm_pc), .dm_rd(dm_rd), .count(count), .empty(empty)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_merge(input st_t s, input logic [31:0] old);
    int sh;
    if (s.op == 2'd1) begin
      sh = s.addr[1] ? 16 : 0;
      return (old & ~(32'h0000FFFF << sh)) | ((s.data & 32'h0000FFFF) << sh);
    end
    if (s.op == 2'd2) begin
      sh = 8 * int'(s.addr[1:0]);
      return (old & ~(32'h000000FF << sh)) | ((s.data & 32'h000000FF) << sh);
    end
    return s.data;
  endfunction
  function automatic bit model_bad(input logic [1:0] op, input logic [31:0] a);
    return (op == 2'd1) ? (a % 2 != 0) : (op == 2'd2) ? 1'b0 : (a % 4 != 0);
  endfunction
  task automatic cyc(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                     input bit g, input bit lv, input logic [31:0] la);
    @(posedge clk);
    #2;
    st_valid = v; st_op = op; st_addr = a; st_data = d; st_pc = 32'h1000 + pc_ctr;
    dm_grant = g; ld_valid = lv; ld_addr = la;
    pc_ctr++;
    exp_mis = v && sb.size() < DEPTH && model_bad(op, a);
    if (v && sb.size() < DEPTH && !model_bad(op, a)) begin
      stage = '{op, a, d, st_pc};
      stage_v = 1;
    end
  endtask
  always begin : occupancy_checker
    @(posedge clk);
    #1;
    if (stage_v) begin
      sb.push_back(stage);
      stage_v = 0;
    end
    if (!reset) begin
      chk("count", 32'(count), sb.size());
      chk("st_ready", 32'(st_ready), 32'(sb.size() < DEPTH));
      chk("empty", 32'(empty), 32'(sb.size() == 0));
      chk("st_misalign", 32'(st_misalign), 32'(exp_mis));
    end
  end
  always begin : dm_monitor
    st_t         s;
    bit          hit, yword;
    logic [31:0] ydata;
    @(negedge clk);
    if (!reset) begin
      hit = 0; yword = 0; ydata = '0;
      foreach (sb[i])
        if (sb[i].addr[31:2] == ld_addr[31:2]) begin
          hit = 1;
          yword = sb[i].op == 2'd0 || sb[i].op == 2'd3;
          ydata = sb[i].data;
        end
`ifdef DM_STORE_BUF_FWD_EN
      chk("ld_hazard", 32'(ld_hazard), 32'(ld_valid && hit && !yword));
      chk("ld_fwd_valid", 32'(ld_fwd_valid), 32'(ld_valid && hit && yword));
      if (ld_valid && hit && yword) chk("ld_fwd_data", ld_fwd_data, ydata);
`else
      chk("ld_hazard", 32'(ld_hazard), 32'(ld_valid && hit));
`endif
      chk("dm_req", 32'(dm_req), 32'(sb.size() != 0));
      if (dm_we) begin
        chk("we_needs_grant", 32'(dm_grant), 32'd1);
        if (sb.size() == 0) chk("dm_we_spurious", 32'(dm_we), 32'd0);
        else begin
          s = sb.pop_front();
          chk("dm_addr", dm_addr, {s.addr[31:2], 2'b00});
          chk("dm_wd", dm_wd, model_merge(s, ram[s.addr[7:2]]));
          chk("dm_pc", dm_pc, s.pc);
        end
        ram[dm_addr[7:2]] = dm_wd;
      end
    end
  end
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h01010101 * i;
    ld_valid = 1'b1;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(st_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_dm_req", 32'(dm_req), 0);
    chk("rst_dm_we", 32'(dm_we), 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wd", dm_wd, 0);
    chk("rst_dm_pc", dm_pc, 0);
    chk("rst_misalign", 32'(st_misalign), 0);
    chk("rst_ld_hazard", 32'(ld_hazard), 0);
    #9 reset = 1'b0;
    cyc(1, 2'd0, 32'h10, 32'hDEADBEEF, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sw_we_next_cycle", 32'(dm_we), 1);
    chk("sw_addr", dm_addr, 32'h10);
    chk("sw_wd", dm_wd, 32'hDEADBEEF);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sw_count_back_0", 32'(count), 0);
    ram[4] = 32'h11223344;
    cyc(1, 2'd2, 32'h12, 32'hAA, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sb_read_no_we", 32'(dm_we), 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sb_we", 32'(dm_we), 1);
    chk("sb_wd", dm_wd, 32'h11AA3344);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    #1 ram[4] = 32'h11223344;
    cyc(1, 2'd1, 32'h12, 32'hBEEF, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sh_we", 32'(dm_we), 1);
    chk("sh_wd", dm_wd, 32'hBEEF3344);
    cyc(1, 2'd1, 32'h11, 32'h1234, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sh_misalign_pulse", 32'(st_misalign), 1);
    chk("sh_misalign_count", 32'(count), 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sh_misalign_ends", 32'(st_misalign), 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 2'd0, 32'h20 + 4 * i, $urandom, 0, 0, 0);
    cyc(1, 2'd0, 32'h3C, 32'h55555555, 0, 0, 0);
    @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_not_ready", 32'(st_ready), 0);
    for (int i = 0; i < 8; i++) cyc(0, 2'd0, 0, 0, 1, 0, 0);
    ram[5] = 32'hAABBCCDD;
    cyc(1, 2'd2, 32'h15, 32'h55, 1, 1, 32'h14);
    cyc(0, 2'd0, 0, 0, 1, 1, 32'h14);
    cyc(0, 2'd0, 0, 0, 0, 1, 32'h14);
    ram[5] = 32'h01020304;
    cyc(0, 2'd0, 0, 0, 1, 1, 32'h14);
    @(negedge clk);
    chk("reread_no_we", 32'(dm_we), 0);
    chk("reread_hazard", 32'(ld_hazard), 1);
    cyc(0, 2'd0, 0, 0, 1, 1, 32'h14);
    @(negedge clk);
    chk("reread_we", 32'(dm_we), 1);
    chk("reread_wd", dm_wd, 32'h01025504);
    chk("hazard_until_write", 32'(ld_hazard), 1);
    cyc(0, 2'd0, 0, 0, 1, 1, 32'h14);
    @(negedge clk);
    chk("hazard_cleared", 32'(ld_hazard), 0);
`ifdef DM_STORE_BUF_FWD_EN
    cyc(1, 2'd0, 32'h18, 32'hCAFEF00D, 0, 1, 32'h1B);
    cyc(0, 2'd0, 0, 0, 0, 1, 32'h1B);
    @(negedge clk);
    chk("fwd_valid", 32'(ld_fwd_valid), 1);
    chk("fwd_data", ld_fwd_data, 32'hCAFEF00D);
    chk("fwd_no_hazard", 32'(ld_hazard), 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 0, 1, 0, 0);
`endif
    ram[6] = 32'h12345678;
    cyc(1, 2'd2, 32'h1A, 32'h77, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_rmw_we", 32'(dm_we), 0);
    chk("rst_mid_rmw_count", 32'(count), 0);
    sb.delete();
    stage_v = 0;
    exp_mis = 1'b0;
    @(negedge clk);
    chk("rst_no_partial", ram[6], 32'h12345678);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit g;
      g = $urandom_range(0, 3) != 0;
      cyc($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom,
          g, $urandom_range(0, 1) == 1, $urandom_range(0, 31));
      if (!g && $urandom_range(0, 1) == 1) ram[$urandom_range(0, 7)] = $urandom;
    end
    for (int i = 0; i < 200 && (sb.size() != 0 || stage_v); i++) cyc(0, 2'd0, 0, 0, 1, 0, 0);
    if (sb.size() != 0 || stage_v) chk("drain_timeout", sb.size(), 0);
    cyc(0, 2'd0, 0, 0, 1, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
